mem_access_sequencer: RTL and testbench
=======================================

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of wait cycles per byte beat before the access aborts.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_re  input  1  load request, from control bundle data_mem_re.
REQ-005 req_we  input  1  store request, from control bundle data_mem_we.
REQ-006 req_size  input  2  access size: 00 byte, 01 halfword, 11 word; 10 is illegal.
REQ-007 req_signed  input  1  sign-extend the load result.
REQ-008 req_addr  input  32  byte address, from ALU result.
REQ-009 req_wdata  input  32  store data; the low N bytes are used.
REQ-010 stall_out  output  1  pipeline stall request.
REQ-011 rdata_out  output  32  extended load result.
REQ-012 rdata_valid_out  output  1  one-cycle pulse: load result valid.
REQ-013 err_out  output  1  one-cycle pulse: access faulted (illegal size, misaligned, re&we, or timeout).
REQ-014 mem_addr  output  32  byte-memory address.
REQ-015 mem_wdata  output  8  byte-memory write data.
REQ-016 mem_re  output  1  byte-memory read strobe.
REQ-017 mem_we  output  1  byte-memory write strobe.
REQ-018 mem_rdata  input  8  byte-memory read data, valid when mem_ready is high.
REQ-019 mem_ready  input  1  byte-memory beat completion.

Function
REQ-020 SHALL implement the states IDLE, ACCESS and DONE.
REQ-021 IDLE: when req_re|req_we is high, SHALL latch addr, wdata, size and signed, and clear the beat index k and the wait counter.
- Legal request -> next state ACCESS.
- Fault -> next state DONE with a fault flag set; no mem strobe is driven.
REQ-022 Fault conditions SHALL be: size 10; halfword with addr[0]=1; word with addr[1:0]!=0; req_re and req_we both high.
REQ-023 Beat count N SHALL be 1, 2 or 4 for byte, halfword or word respectively.
REQ-024 ACCESS SHALL drive the following combinationally from state:
- mem_addr = latched addr + k;
- mem_re = latched re; mem_we = latched we;
- mem_wdata = store byte k, where byte 0 is the most significant of the low N bytes (big-endian).
REQ-025 ACCESS with mem_ready high SHALL capture mem_rdata into load byte k (big-endian), increment k and clear the wait counter.
- If k = N-1, next state DONE.
REQ-026 ACCESS with mem_ready low SHALL increment the wait counter.
- When the counter reaches TIMEOUT-1 with mem_ready still low, next state DONE with the fault flag set.
REQ-027 DONE SHALL last exactly one cycle and then return to IDLE.
- Loads without fault: rdata_valid_out=1.
- Any fault: err_out=1.
- Stores without fault: neither pulse.
REQ-028 rdata_out SHALL hold the assembled N-byte value, zero-extended or sign-extended to 32 bits per the latched signed bit.
- It is held until the next load completes; it is 0 after a fault.
REQ-029 stall_out SHALL be high in IDLE when a request is present, high throughout ACCESS, and low in DONE and in idle with no request.
REQ-030 Request inputs SHALL be ignored in ACCESS and DONE; a request present in DONE is not accepted.
REQ-031 With mem_ready held high, a word access SHALL stall 5 cycles (1 IDLE + 4 ACCESS) and signal completion in cycle 6.
- Byte access: 2 stall cycles. Halfword access: 3 stall cycles.

Reset
REQ-032 reset low SHALL immediately force IDLE, and SHALL clear k, the wait counter, the latched fields and rdata_out.
- All outputs SHALL be 0 while reset is low, including mem_re and mem_we mid-access.
REQ-033 After reset deassertion, the first request SHALL be accepted in the first IDLE cycle it is present.

Verification
REQ-034 Bench SHALL cover the following signed byte load:
- Stimulus: lb, addr 0x1003, mem byte 0x80, ready always high.
- Response: mem_addr 0x1003, stall 2 cycles, rdata 0xFFFFFF80 with a valid pulse.
REQ-035 Bench SHALL cover the following word store with wait states:
- Stimulus: sw, addr 0x2000, wdata 0x11223344, ready high every 2nd cycle.
- Response: bytes 11, 22, 33, 44 at addresses 2000..2003; mem_we only in ACCESS; no valid pulse.
REQ-036 Bench SHALL cover the following misaligned access:
- Stimulus: lh at 0x0001.
- Response: no mem_re; err pulse in cycle 2; stall 1 cycle; rdata 0.
REQ-037 Bench SHALL cover the following timeout:
- Stimulus: lw, mem_ready stuck low.
- Response: err pulse after exactly TIMEOUT wait cycles on beat 0; return to IDLE.
REQ-038 Bench SHALL cover reset mid-access:
- Stimulus: reset low during beat 2 of a word load.
- Response: mem_re drops asynchronously; IDLE after release; no valid pulse.
REQ-039 Bench SHALL cover the following unsigned halfword load:
- Stimulus: lhu at 0x0010, bytes 0xFE, 0xDC.
- Response: rdata 0x0000FEDC.

Source files
------------

// File: rtl/mem_access_sequencer_if.sv
// Byte-wide memory port between the access sequencer (master) and a byte memory (slave).
interface mem_access_sequencer_if;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_re,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_re,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Breaks a byte/halfword/word load or store into big-endian byte beats on a byte memory,
// stalling the pipeline until the access completes, faults, or times out.
module mem_access_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_re,
    input  logic                          req_we,
    input  logic [1:0]                    req_size,
    input  logic                          req_signed,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   req_wdata,
    output logic                          stall_out,
    output logic [31:0]                   rdata_out,
    output logic                          rdata_valid_out,
    output logic                          err_out,
    mem_access_sequencer_if.master        mem
);

    localparam int unsigned     WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       load_q, load_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        k_q, k_d;
    logic              signed_q, signed_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              fault_q, fault_d;
    logic [WaitW-1:0]  wait_q, wait_d;

    logic              req_fault;
    logic [31:0]       assembled;
    logic [31:0]       extended;
    logic [1:0]        byte_idx;
    logic [7:0]        store_byte;

    assign req_fault = (req_re & req_we) |
                       (req_size == 2'b10) |
                       ((req_size == 2'b01) & req_addr[0]) |
                       ((req_size == 2'b11) & (req_addr[1:0] != 2'b00));

    // Beats arrive most-significant first, so shifting left assembles a big-endian value.
    assign assembled = {load_q[23:0], mem.mem_rdata};

    always_comb begin
        extended = assembled;
        unique case (size_q)
            2'b00:   extended = {{24{signed_q & assembled[7]}}, assembled[7:0]};
            2'b01:   extended = {{16{signed_q & assembled[15]}}, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    // Legal size encodings equal N-1, so size - k is the byte lane of beat k.
    assign byte_idx = size_q - k_q;

    always_comb begin
        store_byte = 8'h00;
        unique case (byte_idx)
            2'd0: store_byte = wdata_q[7:0];
            2'd1: store_byte = wdata_q[15:8];
            2'd2: store_byte = wdata_q[23:16];
            2'd3: store_byte = wdata_q[31:24];
        endcase
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        load_d          = load_q;
        rdata_d         = rdata_q;
        size_d          = size_q;
        k_d             = k_q;
        signed_d        = signed_q;
        re_d            = re_q;
        we_d            = we_q;
        fault_d         = fault_q;
        wait_d          = wait_q;
        stall_out       = 1'b0;
        rdata_valid_out = 1'b0;
        err_out         = 1'b0;
        mem.mem_addr    = 32'h0;
        mem.mem_wdata   = 8'h00;
        mem.mem_re      = 1'b0;
        mem.mem_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated so the stall request is also low while held in reset.
                stall_out = reset & (req_re | req_we);
                if (req_re | req_we) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    size_d   = req_size;
                    signed_d = req_signed;
                    re_d     = req_re;
                    we_d     = req_we;
                    k_d      = 2'd0;
                    wait_d   = '0;
                    load_d   = 32'h0;
                    fault_d  = req_fault;
                    if (req_fault) begin
                        rdata_d = 32'h0;
                        state_d = StDone;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                stall_out     = 1'b1;
                mem.mem_addr  = addr_q + {30'b0, k_q};
                mem.mem_re    = re_q;
                mem.mem_we    = we_q;
                mem.mem_wdata = store_byte;
                if (mem.mem_ready) begin
                    load_d = assembled;
                    k_d    = k_q + 2'd1;
                    wait_d = '0;
                    if (k_q == size_q) begin
                        state_d = StDone;
                        if (re_q) rdata_d = extended;
                    end
                end else if (wait_q == WaitLast) begin
                    fault_d = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StDone;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDone: begin
                rdata_valid_out = re_q & ~fault_q;
                err_out         = fault_q;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rdata_out = rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            load_q   <= 32'h0;
            rdata_q  <= 32'h0;
            size_q   <= 2'b00;
            k_q      <= 2'd0;
            signed_q <= 1'b0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            load_q   <= load_d;
            rdata_q  <= rdata_d;
            size_q   <= size_d;
            k_q      <= k_d;
            signed_q <= signed_d;
            re_q     <= re_d;
            we_q     <= we_d;
            fault_q  <= fault_d;
            wait_q   <= wait_d;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: a driver predicts beats, results and stall lengths
// from the access rules; an independent monitor compares what the DUT presents.
module tb_mem_access_sequencer;

    localparam int unsigned TO = 16;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [7:0]  data;
    } beat_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        int          stall;
        int          strobes;
        int          pulse;
        logic [31:0] rdata;
    } txn_t;

    logic        clk;
    logic        reset;
    logic        req_re;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_out;
    logic [31:0] rdata_out;
    logic        rdata_valid_out;
    logic        err_out;

    mem_access_sequencer_if mif ();

    mem_access_sequencer #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_re          (req_re),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .stall_out       (stall_out),
        .rdata_out       (rdata_out),
        .rdata_valid_out (rdata_valid_out),
        .err_out         (err_out),
        .mem             (mif.master)
    );

    logic [7:0]  mem [0:4095];
    assign mif.mem_rdata = mem[mif.mem_addr[11:0]];

    beat_t       beat_q [$];
    resp_t       resp_q [$];
    txn_t        txn_q  [$];
    int          checks;
    int          errors;
    int          ready_mode;  // 0 always high, 1 alternate, 2 stuck low, 3 random
    logic [31:0] exp_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input bit sgn);
        logic [63:0] v;
        logic [31:0] a;
        v = 64'h0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v = (v << 8) | 64'(mem[a[11:0]]);
        end
        if (sgn && v[8*n-1]) v = v + (64'h1_0000_0000 - (64'd1 << (8 * n)));
        return v[31:0];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bit r;
        bit phase;
        int lowrun;
        phase  = 1'b0;
        lowrun = 0;
        mif.mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: r = 1'b1;
                1: begin phase = ~phase; r = phase; end
                2: r = 1'b0;
                default: r = ($urandom_range(0, 1) == 1) || (lowrun >= 3);
            endcase
            lowrun = r ? 0 : lowrun + 1;
            mif.mem_ready = r;
        end
    end

    // Monitor: compares bus beats, result pulses and stall-run lengths against the queues.
    initial begin
        int    stall_cnt;
        int    strobe_cnt;
        beat_t b;
        resp_t rs;
        txn_t  t;
        stall_cnt  = 0;
        strobe_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_cnt  = 0;
                strobe_cnt = 0;
            end else begin
                if (rdata_valid_out || err_out) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_pulse", {30'b0, err_out, rdata_valid_out}, 32'h0);
                    end else begin
                        rs = resp_q.pop_front();
                        check("pulse_kind", {30'b0, err_out, rdata_valid_out},
                              rs.err ? 32'h2 : 32'h1);
                        check("rdata", rdata_out, rs.rdata);
                    end
                end
                if (mif.mem_re || mif.mem_we) begin
                    strobe_cnt++;
                    check("strobe_while_stalled", 32'(stall_out), 32'h1);
                    if (mif.mem_ready) begin
                        if (beat_q.size() == 0) begin
                            check("unexpected_beat", mif.mem_addr, 32'hFFFF_FFFF);
                        end else begin
                            b = beat_q.pop_front();
                            check("beat_strobes", {30'b0, mif.mem_re, mif.mem_we},
                                  b.we ? 32'h1 : 32'h2);
                            check("beat_addr", mif.mem_addr, b.addr);
                            if (b.we) check("beat_wdata", 32'(mif.mem_wdata), 32'(b.data));
                        end
                    end
                end
                if (stall_out) begin
                    stall_cnt++;
                end else if (stall_cnt > 0) begin
                    if (txn_q.size() == 0) begin
                        check("unexpected_stall_run", 32'(stall_cnt), 32'h0);
                    end else begin
                        t = txn_q.pop_front();
                        if (t.stall >= 0) check("stall_cycles", 32'(stall_cnt), 32'(t.stall));
                        if (t.strobes >= 0) check("strobe_cycles", 32'(strobe_cnt), 32'(t.strobes));
                        check("done_pulse", {30'b0, err_out, rdata_valid_out}, 32'(t.pulse));
                        check("rdata_hold", rdata_out, t.rdata);
                    end
                    stall_cnt  = 0;
                    strobe_cnt = 0;
                end
            end
        end
    end

    // Predicts one access, then drives it; entered and left at posedge+1 with the DUT idle.
    task automatic issue(input bit re, input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int mode,
                         input bit garbage);
        bit          fault;
        bit          done;
        int          n;
        txn_t        t;
        resp_t       rs;
        beat_t       b;
        logic [31:0] a;
        logic [31:0] sh;
        fault = (re && we) || (size == 2'b10) || (size == 2'b01 && addr[0]) ||
                (size == 2'b11 && addr[1:0] != 2'b00);
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        t.stall   = -1;
        t.strobes = -1;
        t.pulse   = 0;
        if (fault || mode == 2) begin
            t.stall   = fault ? 1 : 1 + int'(TO);
            t.strobes = fault ? 0 : int'(TO);
            t.pulse   = 2;
            exp_hold  = 32'h0;
            rs.err    = 1'b1;
            rs.rdata  = 32'h0;
            resp_q.push_back(rs);
        end else begin
            if (mode == 0) begin
                t.stall   = 1 + n;
                t.strobes = n;
            end
            if (re) begin
                exp_hold = ref_load(addr, n, sgn);
                rs.err   = 1'b0;
                rs.rdata = exp_hold;
                resp_q.push_back(rs);
                t.pulse  = 1;
            end
            for (int i = 0; i < n; i++) begin
                a      = addr + 32'(i);
                sh     = wdata >> (8 * (n - 1 - i));
                b.we   = we;
                b.addr = a;
                b.data = we ? sh[7:0] : 8'h00;
                beat_q.push_back(b);
                if (we) mem[a[11:0]] = sh[7:0];
            end
        end
        t.rdata = exp_hold;
        txn_q.push_back(t);

        ready_mode = mode;
        req_re     = re;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        if (garbage) begin
            req_re     = 1'($urandom);
            req_we     = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end else begin
            req_re = 1'b0;
            req_we = 1'b0;
        end
        done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!stall_out) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("access_completes", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        req_re = 1'b0;
        req_we = 1'b0;
    endtask

    initial begin
        bit          re;
        bit          we;
        int          sel;
        logic [1:0]  size;
        logic [31:0] addr;
        int          mode;
        checks     = 0;
        errors     = 0;
        exp_hold   = 32'h0;
        ready_mode = 0;
        reset      = 1'b0;
        req_re     = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h003] = 8'h80;
        mem[12'h010] = 8'hFE;
        mem[12'h011] = 8'hDC;

        // Outputs must stay quiet under reset even with a request present.
        #1 req_re = 1'b1;
        #2;
        check("reset_stall", 32'(stall_out), 32'h0);
        check("reset_outputs", {29'b0, rdata_valid_out, err_out, mif.mem_re | mif.mem_we},
              32'h0);
        check("reset_rdata", rdata_out, 32'h0);
        check("reset_mem_addr", mif.mem_addr, 32'h0);
        req_re = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        issue(1, 0, 2'b00, 1, 32'h0000_1003, 32'h0, 0, 0);          // lb, expect 0xFFFFFF80
        issue(0, 1, 2'b11, 0, 32'h0000_2000, 32'h1122_3344, 1, 0);  // sw with wait states
        issue(1, 0, 2'b01, 1, 32'h0000_0001, 32'h0, 0, 0);          // misaligned lh
        issue(1, 0, 2'b11, 0, 32'h0000_0040, 32'h0, 2, 0);          // lw timeout
        issue(1, 0, 2'b01, 0, 32'h0000_0010, 32'h0, 0, 1);          // lhu, expect 0x0000FEDC

        // Reset during beat 2 of a word load.
        ready_mode = 0;
        for (int i = 0; i < 2; i++) begin
            beat_t b;
            b.we   = 1'b0;
            b.addr = 32'h100 + 32'(i);
            b.data = 8'h00;
            beat_q.push_back(b);
        end
        req_re   = 1'b1;
        req_size = 2'b11;
        req_addr = 32'h0000_0100;
        @(posedge clk);
        #1 req_re = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_beat2_addr", mif.mem_addr, 32'h0000_0102);
        reset = 1'b0;
        #1;
        check("reset_drops_mem_re", 32'(mif.mem_re), 32'h0);
        check("reset_drops_stall", 32'(stall_out), 32'h0);
        check("reset_clears_rdata", rdata_out, 32'h0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        exp_hold = 32'h0;
        @(negedge clk);
        check("idle_after_reset", {30'b0, stall_out, mif.mem_re}, 32'h0);
        @(posedge clk);
        #1;

        for (int it = 0; it < 250; it++) begin
            sel = int'($urandom % 20);
            re  = (sel < 9) || (sel >= 18);
            we  = (sel >= 9);
            size = 2'($urandom);
            addr = $urandom % 4096;
            if ($urandom % 4 != 0) begin
                if (size == 2'b11) addr[1:0] = 2'b00;
                else if (size == 2'b01) addr[0] = 1'b0;
            end
            sel  = int'($urandom % 8);
            mode = (sel < 4) ? 0 : (sel < 6) ? 3 : (sel == 6) ? 1 : 2;
            issue(re, we, size, 1'($urandom), addr, $urandom, mode, ($urandom % 4) == 0);
        end

        repeat (5) @(posedge clk);
        check("beats_left", 32'(beat_q.size()), 32'h0);
        check("responses_left", 32'(resp_q.size()), 32'h0);
        check("transactions_left", 32'(txn_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
